csr_tx_fifo: RTL and testbench

CSR_TX_FIFO -- requirements
Module: csr_tx_fifo

---
 rtl/csr_tx_fifo.sv | 74 +++++++
 tb/tb_csr_tx_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/csr_tx_fifo.sv
// csr_tx_fifo: CSR-written 16-bit transmit FIFO with a valid/ack stream output
// and a thresholded active-low DMA request.
module csr_tx_fifo #(
   parameter logic [3:0] csr_addr = 4'h0,
   parameter int depth_log2 = 5
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [13:0] csr_adr,
   input  logic        csr_we,
   input  logic [15:0] csr_dat_w,
   output logic [15:0] csr_dat_r,
   output logic        stb,
   input  logic        ack,
   output logic [15:0] data,
   output logic        dmareq_n
);
   localparam int lw = depth_log2 + 1;
   localparam logic [depth_log2:0] full_lvl = {1'b1, {depth_log2{1'b0}}};
   localparam logic [depth_log2:0] half_lvl = {2'b01, {(depth_log2 - 1){1'b0}}};
   logic [15:0] mem [1 << depth_log2];
   logic [depth_log2-1:0] wr_ptr, rd_ptr;
   logic [depth_log2:0] level, thresh, free;
   logic ovf, sel, empty, full, wr_data, wr_ctrl, push, pop, flush, adr_unused;
   logic [15:0] rd_mux;
   assign adr_unused = ^csr_adr[9:2];
   assign sel = csr_adr[13:10] == csr_addr;
   assign wr_data = sel & csr_we & (csr_adr[1:0] == 2'd0);
   assign wr_ctrl = sel & csr_we & (csr_adr[1:0] == 2'd2);
   assign flush = wr_ctrl & csr_dat_w[0];
   assign empty = level == '0;
   assign full = level == full_lvl;
   assign push = wr_data & ~full;
   assign pop = ~empty & ack;
   assign free = full_lvl - level;
   assign stb = ~empty;
   assign data = mem[rd_ptr];
   assign rd_mux = ~sel ? 16'h0 :
                   csr_adr[1:0] == 2'd1 ? 16'(level) :
                   csr_adr[1:0] == 2'd2 ? {13'h0, full, ovf, empty} :
                   csr_adr[1:0] == 2'd3 ? 16'(thresh) : 16'h0;
   // Storage is left unreset so it maps onto RAM primitives.
   always_ff @(posedge sys_clk)
      if (push)
         mem[wr_ptr] <= csr_dat_w;
   always_ff @(posedge sys_clk)
      if (sys_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
         ovf <= 1'b0;
         thresh <= half_lvl;
         csr_dat_r <= 16'h0;
         dmareq_n <= 1'b0;
      end else begin
         csr_dat_r <= rd_mux;
         dmareq_n <= ~(free >= thresh);
         if (wr_data & full)
            ovf <= 1'b1;
         else if (wr_ctrl & csr_dat_w[1])
            ovf <= 1'b0;
         if (sel & csr_we & (csr_adr[1:0] == 2'd3))
            thresh <= csr_dat_w[depth_log2:0];
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
         end else begin
            wr_ptr <= push ? wr_ptr + depth_log2'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + depth_log2'(1) : rd_ptr;
            level <= level + lw'(push) - lw'(pop);
         end
      end
endmodule

// File: tb/tb_csr_tx_fifo.sv
// tb_csr_tx_fifo: directed self-checking bench for csr_tx_fifo at default parameters.
module tb_csr_tx_fifo;
   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [13:0] csr_adr = '0;
   logic        csr_we = 1'b0;
   logic [15:0] csr_dat_w = '0;
   logic [15:0] csr_dat_r;
   logic        stb;
   logic        ack = 1'b0;
   logic [15:0] data;
   logic        dmareq_n;
   int n_total = 0;
   int n_pass = 0;

   csr_tx_fifo dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_adr(csr_adr), .csr_we(csr_we),
      .csr_dat_w(csr_dat_w), .csr_dat_r(csr_dat_r), .stb(stb), .ack(ack),
      .data(data), .dmareq_n(dmareq_n)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic wr(input logic [13:0] a, input logic [15:0] d);
      csr_adr = a;
      csr_dat_w = d;
      csr_we = 1'b1;
      tick;
      csr_we = 1'b0;
   endtask

   task automatic rdchk(input string tag, input logic [13:0] a, input logic [15:0] exp);
      csr_adr = a;
      tick;
      chk(tag, csr_dat_r, exp);
   endtask

   task automatic pop1;
      ack = 1'b1;
      tick;
      ack = 1'b0;
   endtask

   initial begin
      tick;
      tick;
      sys_rst = 1'b0;
      chk("rst_dat_r", csr_dat_r, 16'h0);
      chk("rst_stb", 16'(stb), 16'h0);
      chk("rst_dmareq", 16'(dmareq_n), 16'h0);
      rdchk("rst_level", 14'd1, 16'h0);
      rdchk("rst_stat", 14'd2, 16'h0001);
      rdchk("rst_thresh", 14'd3, 16'd16);
      // two words in, one out
      wr(14'd0, 16'h1234);
      wr(14'd0, 16'hABCD);
      chk("two_stb", 16'(stb), 16'h1);
      chk("two_head", data, 16'h1234);
      rdchk("two_level", 14'd1, 16'd2);
      pop1;
      chk("pop_head", data, 16'hABCD);
      rdchk("pop_level", 14'd1, 16'd1);
      rdchk("data_reg_read", 14'd0, 16'h0);
      pop1;
      chk("drained_stb", 16'(stb), 16'h0);
      pop1;
      rdchk("ack_empty_level", 14'd1, 16'h0);
      // other bank ignored; middle address bits ignored
      wr(14'h0400, 16'h5555);
      wr(14'h0402, 16'h0003);
      rdchk("bank_level", 14'd1, 16'h0);
      rdchk("bank_dat_r", 14'h0401, 16'h0);
      wr(14'h03FC, 16'h7777);
      rdchk("alias_level", 14'h03FD, 16'd1);
      chk("alias_head", data, 16'h7777);
      pop1;
      // overfill by one
      for (int i = 0; i < 33; i++) wr(14'd0, 16'(i));
      rdchk("full_level", 14'd1, 16'd32);
      rdchk("full_stat", 14'd2, 16'h0006);
      chk("full_dmareq", 16'(dmareq_n), 16'h1);
      wr(14'd2, 16'h0002);
      rdchk("ovf_clr_stat", 14'd2, 16'h0004);
      // push into full with simultaneous pop
      csr_adr = 14'd0;
      csr_dat_w = 16'hBEEF;
      csr_we = 1'b1;
      ack = 1'b1;
      tick;
      csr_we = 1'b0;
      ack = 1'b0;
      chk("fullpp_head", data, 16'd1);
      rdchk("fullpp_level", 14'd1, 16'd31);
      rdchk("fullpp_stat", 14'd2, 16'h0002);
      for (int i = 1; i < 32; i++) begin
         chk("fullpp_order", data, 16'(i));
         pop1;
      end
      chk("fullpp_empty", 16'(stb), 16'h0);
      wr(14'd2, 16'h0002);
      // flush with concurrent ack
      for (int i = 0; i < 10; i++) wr(14'd0, 16'h0100 + 16'(i));
      csr_adr = 14'd2;
      csr_dat_w = 16'h0001;
      csr_we = 1'b1;
      ack = 1'b1;
      tick;
      csr_we = 1'b0;
      ack = 1'b0;
      chk("flush_stb", 16'(stb), 16'h0);
      rdchk("flush_level", 14'd1, 16'h0);
      rdchk("flush_stat", 14'd2, 16'h0001);
      // threshold and DMA request
      wr(14'd3, 16'hFFE8);
      rdchk("thresh_mask", 14'd3, 16'h0028);
      wr(14'd3, 16'd8);
      for (int i = 0; i < 24; i++) wr(14'd0, 16'(i));
      tick;
      chk("dma_free8", 16'(dmareq_n), 16'h0);
      wr(14'd0, 16'h0099);
      chk("dma_lag", 16'(dmareq_n), 16'h0);
      tick;
      chk("dma_free7", 16'(dmareq_n), 16'h1);
      pop1;
      tick;
      chk("dma_pop", 16'(dmareq_n), 16'h0);
      wr(14'd2, 16'h0001);
      // wraparound: 100 push/pop pairs
      wr(14'd0, 16'h2000);
      for (int i = 0; i < 100; i++) begin
         chk("wrap_order", data, 16'h2000 + 16'(i));
         csr_adr = 14'd0;
         csr_dat_w = 16'h2000 + 16'(i + 1);
         csr_we = 1'b1;
         ack = 1'b1;
         tick;
      end
      csr_we = 1'b0;
      ack = 1'b0;
      rdchk("wrap_level", 14'd1, 16'd1);
      chk("wrap_head", data, 16'h2064);
      // reset mid-transfer beats write and ack
      wr(14'd0, 16'h0A0A);
      wr(14'd3, 16'd2);
      sys_rst = 1'b1;
      csr_adr = 14'd0;
      csr_dat_w = 16'hDEAD;
      csr_we = 1'b1;
      ack = 1'b1;
      tick;
      sys_rst = 1'b0;
      csr_we = 1'b0;
      ack = 1'b0;
      chk("rst2_stb", 16'(stb), 16'h0);
      chk("rst2_dmareq", 16'(dmareq_n), 16'h0);
      rdchk("rst2_level", 14'd1, 16'h0);
      rdchk("rst2_thresh", 14'd3, 16'd16);
      wr(14'd0, 16'hCAFE);
      chk("rst2_stb_push", 16'(stb), 16'h1);
      chk("rst2_head", data, 16'hCAFE);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
